// File: rtl/warplc_pkg.sv
// ----------------------------------------------------------------------------
// warplc_pkg
//   Shared definitions for the FSB fill controller: the cycle-controller state
//   encoding, the latched CPU request record, default geometry, and the helper
//   that sizes the word-within-line index.
// ----------------------------------------------------------------------------
package warplc_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;   // 32-bit words per fill line
    localparam int unsigned AW_DEF         = 26;  // word-address width (FSB_A[27:2])

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        FILL     = 3'd2,
        UNC      = 3'd3,
        TERM     = 3'd4,
        WAIT_NAS = 3'd5
    } fsb_state_e;

    // CPU cycle attributes captured at the falling edge of CPU_nAS.
    typedef struct packed {
        logic        rnw;
        logic        cacheable;
        logic [3:0]  be;
        logic [31:0] wd;
    } fsb_req_t;

    // Width of the word index inside one line. A 2-word line still needs one bit.
    function automatic int unsigned idx_width(input int unsigned line_words);
        return (line_words <= 2) ? 1 : $clog2(line_words);
    endfunction

endpackage

// File: rtl/fsb_fill_ctrl_fill_addr_gen.sv
// ----------------------------------------------------------------------------
// fill_addr_gen
//   Word sequencer for a line fill. Loads the critical-word index, steps it
//   modulo LINE_WORDS on each accepted word, and flags the last word of the
//   line. The line base is held by the caller; only the low index moves.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   start a new line at start_idx (word count cleared)
//   start_idx  in   critical-word index (low address bits)
//   advance    in   current word accepted; step to the next one
//   idx        out  current word index within the line
//   last       out  current word is the final word of the line
// ----------------------------------------------------------------------------
module fill_addr_gen
    import warplc_pkg::*;
#(
    parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
    localparam int unsigned IW         = idx_width(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [IW-1:0] start_idx,
    input  logic          advance,
    output logic [IW-1:0] idx,
    output logic          last
);

    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;   // words already accepted in this line

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (load) begin
            idx_d = start_idx;
            cnt_d = '0;
        end else if (advance) begin
            // LINE_WORDS is a power of two, so natural overflow is the modulo wrap.
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign idx  = idx_q;
    assign last = (cnt_q == IW'(LINE_WORDS - 1));

endmodule

// File: rtl/fsb_fill_ctrl.sv
// ----------------------------------------------------------------------------
// fsb_fill_ctrl
//   FSB cycle controller between the CPU bus and L2Prefetch. Each CPU_nAS
//   cycle is looked up in the prefetch buffer; a cacheable read miss fills the
//   whole line (critical word first) through the L2 write port, then looks up
//   again. Uncached accesses and all writes go straight to memory. Every
//   completed cycle is terminated with a single-cycle CPU_nSTERM.
//
// Configuration macro
//   WARPLC_WRITE_UPDATE_EN  defined  : a cacheable write updates the L2 line
//                                      (L2_WR with L2_WRM=B, L2_WRD=WD)
//                           undefined: a cacheable write invalidates L2 (L2_CLR)
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   CPU_nAS, CPU_RnW         address strobe (active low), 1=read 0=write
//   FSB_A, FSB_B, FSB_WD     word address, byte enables, write data
//   CACHE_CS                 address is cacheable
//   L2_MATCH                 L2Prefetch hit, valid in the LOOKUP cycle
//   L2_WRA/WRD/WR/WRM        L2 write port (WR is a 1-cycle pulse)
//   L2_CLR                   L2 invalidate-all pulse
//   MEM_REQ/WE/A/WD/BE       memory request, held until MEM_ACK
//   MEM_ACK, MEM_RD          1-cycle ack with read data in the same cycle
//   BYP_D, BYP_OE            uncached read data and its FSB drive enable
//   CPU_nSTERM               synchronous termination, active low
// ----------------------------------------------------------------------------
module fsb_fill_ctrl
    import warplc_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned AW         = AW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CPU_nAS,
    input  logic          CPU_RnW,
    input  logic [AW-1:0] FSB_A,
    input  logic [3:0]    FSB_B,
    input  logic [31:0]   FSB_WD,
    input  logic          CACHE_CS,
    input  logic          L2_MATCH,
    output logic [AW-1:0] L2_WRA,
    output logic [31:0]   L2_WRD,
    output logic          L2_WR,
    output logic [3:0]    L2_WRM,
    output logic          L2_CLR,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_A,
    output logic [31:0]   MEM_WD,
    output logic [3:0]    MEM_BE,
    input  logic          MEM_ACK,
    input  logic [31:0]   MEM_RD,
    output logic [31:0]   BYP_D,
    output logic          BYP_OE,
    output logic          CPU_nSTERM
);

    localparam int unsigned IW = idx_width(LINE_WORDS);

    fsb_state_e    state_q,    state_d;
    logic [AW-1:0] a_q,        a_d;
    fsb_req_t      req_q,      req_d;
    logic          aborted_q,  aborted_d;    // nAS rose while the access was in flight
    logic          relookup_q, relookup_d;   // this LOOKUP follows a completed fill

    logic [AW-1:0] l2_wra_q,   l2_wra_d;
    logic [31:0]   l2_wrd_q,   l2_wrd_d;
    logic          l2_wr_q,    l2_wr_d;
    logic [3:0]    l2_wrm_q,   l2_wrm_d;
    logic          l2_clr_q,   l2_clr_d;
    logic          mem_req_q,  mem_req_d;
    logic          mem_we_q,   mem_we_d;
    logic [AW-1:0] mem_a_q,    mem_a_d;
    logic [31:0]   mem_wd_q,   mem_wd_d;
    logic [3:0]    mem_be_q,   mem_be_d;
    logic [31:0]   byp_d_q,    byp_d_d;
    logic          byp_oe_q,   byp_oe_d;
    logic          nsterm_q,   nsterm_d;

    logic          gen_load;
    logic          gen_advance;
    logic [IW-1:0] gen_idx;
    logic          gen_last;
    logic          abort_now;

    fill_addr_gen #(
        .LINE_WORDS (LINE_WORDS)
    ) u_fill_addr_gen (
        .clk       (CLK),
        .rst       (RST),
        .load      (gen_load),
        .start_idx (a_q[IW-1:0]),
        .advance   (gen_advance),
        .idx       (gen_idx),
        .last      (gen_last)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        req_d       = req_q;
        aborted_d   = aborted_q;
        relookup_d  = relookup_q;
        l2_wra_d    = l2_wra_q;
        l2_wrd_d    = l2_wrd_q;
        l2_wr_d     = 1'b0;
        l2_wrm_d    = l2_wrm_q;
        l2_clr_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_a_d     = mem_a_q;
        mem_wd_d    = mem_wd_q;
        mem_be_d    = mem_be_q;
        byp_d_d     = byp_d_q;
        byp_oe_d    = byp_oe_q;
        nsterm_d    = 1'b1;
        gen_load    = 1'b0;
        gen_advance = 1'b0;
        // An abort is recognised in the very cycle nAS is seen high, including the ack cycle.
        abort_now   = aborted_q | CPU_nAS;

        unique case (state_q)
            IDLE: begin
                if (!CPU_nAS) begin
                    a_d        = FSB_A;
                    req_d      = '{rnw: CPU_RnW, cacheable: CACHE_CS, be: FSB_B, wd: FSB_WD};
                    aborted_d  = 1'b0;
                    relookup_d = 1'b0;
                    state_d    = LOOKUP;
                end
            end

            LOOKUP: begin
                relookup_d = 1'b0;
                if (req_q.rnw && req_q.cacheable) begin
                    if (L2_MATCH) begin
                        nsterm_d = 1'b0;
                        state_d  = TERM;
                    end else begin
                        // Critical word is the requested address itself.
                        gen_load  = 1'b1;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_a_d   = a_q;
                        mem_be_d  = 4'hF;
                        state_d   = FILL;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = ~req_q.rnw;
                    mem_a_d   = a_q;
                    mem_wd_d  = req_q.wd;
                    mem_be_d  = req_q.be;
                    state_d   = UNC;
                end
            end

            FILL: begin
                aborted_d = abort_now;
                if (mem_req_q) begin
                    if (MEM_ACK) begin
                        mem_req_d   = 1'b0;
                        l2_wr_d     = 1'b1;
                        l2_wra_d    = mem_a_q;
                        l2_wrd_d    = MEM_RD;
                        l2_wrm_d    = 4'hF;
                        gen_advance = 1'b1;
                        if (gen_last) begin
                            if (abort_now) begin
                                state_d = IDLE;
                            end else begin
                                relookup_d = 1'b1;
                                state_d    = LOOKUP;
                            end
                        end
                    end
                end else begin
                    // Gap cycle after an ack: the index has already stepped.
                    mem_req_d = 1'b1;
                    mem_a_d   = {a_q[AW-1:IW], gen_idx};
                end
            end

            UNC: begin
                aborted_d = abort_now;
                if (mem_req_q && MEM_ACK) begin
                    mem_req_d = 1'b0;
                    if (req_q.rnw) begin
                        byp_d_d  = MEM_RD;
                        byp_oe_d = ~abort_now;
                    end else if (req_q.cacheable) begin
`ifdef WARPLC_WRITE_UPDATE_EN
                        l2_wr_d  = 1'b1;
                        l2_wra_d = a_q;
                        l2_wrd_d = req_q.wd;
                        l2_wrm_d = req_q.be;
`else
                        l2_clr_d = 1'b1;
`endif
                    end
                    if (abort_now) begin
                        state_d = IDLE;
                    end else begin
                        nsterm_d = 1'b0;
                        state_d  = TERM;
                    end
                end
            end

            TERM: begin
                byp_oe_d = 1'b0;
                state_d  = WAIT_NAS;
            end

            WAIT_NAS: begin
                if (CPU_nAS) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: datapath registers are reset too, so every output is defined straight out of reset.
            state_q    <= IDLE;
            a_q        <= '0;
            req_q      <= '0;
            aborted_q  <= 1'b0;
            relookup_q <= 1'b0;
            l2_wra_q   <= '0;
            l2_wrd_q   <= '0;
            l2_wr_q    <= 1'b0;
            l2_wrm_q   <= '0;
            l2_clr_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
            mem_be_q   <= '0;
            byp_d_q    <= '0;
            byp_oe_q   <= 1'b0;
            nsterm_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            req_q      <= req_d;
            aborted_q  <= aborted_d;
            relookup_q <= relookup_d;
            l2_wra_q   <= l2_wra_d;
            l2_wrd_q   <= l2_wrd_d;
            l2_wr_q    <= l2_wr_d;
            l2_wrm_q   <= l2_wrm_d;
            l2_clr_q   <= l2_clr_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            mem_wd_q   <= mem_wd_d;
            mem_be_q   <= mem_be_d;
            byp_d_q    <= byp_d_d;
            byp_oe_q   <= byp_oe_d;
            nsterm_q   <= nsterm_d;
        end
    end

    assign L2_WRA     = l2_wra_q;
    assign L2_WRD     = l2_wrd_q;
    assign L2_WR      = l2_wr_q;
    assign L2_WRM     = l2_wrm_q;
    assign L2_CLR     = l2_clr_q;
    assign MEM_REQ    = mem_req_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_A      = mem_a_q;
    assign MEM_WD     = mem_wd_q;
    assign MEM_BE     = mem_be_q;
    assign BYP_D      = byp_d_q;
    assign BYP_OE     = byp_oe_q;
    assign CPU_nSTERM = nsterm_q;

`ifndef SYNTHESIS
    // A line that was just filled must hit; a miss here means the L2 dropped the fill.
    refill_hit_a: assert property (@(posedge CLK) disable iff (RST)
        (state_q == LOOKUP && relookup_q) |-> L2_MATCH)
        else $error("fsb_fill_ctrl: miss on re-lookup after line fill");
`endif

endmodule
